// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param. The producer/consumer side
// uses the master modport; the FIFO itself uses the slave modport.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
);
    logic [DATA_W-1:0] din;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   data_count;
    logic              overflow;
    logic              underflow;

    modport master (
        output din, wr_en, rd_en,
        input  dout, full, empty, almost_full, almost_empty, data_count, overflow, underflow
    );

    modport slave (
        input  din, wr_en, rd_en,
        output dout, full, empty, almost_full, almost_empty, data_count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost flags and overflow/underflow strobes.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default build is standard mode.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 11,
    parameter int AFULL_TH  = 2040,
    parameter int AEMPTY_TH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    sync_fifo_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_p0;
    logic [CNT_W-1:0]  count_nxt;
    logic [DATA_W-1:0] dout_p0;
    logic              full_p0;
    logic              empty_p0;
    logic              afull_p0;
    logic              aempty_p0;
    logic              ovf_p0;
    logic              udf_p0;
    logic              wr_acc;
    logic              rd_acc;
    logic              ram_pop;

    function automatic logic [CNT_W-1:0] cnt_step(logic [CNT_W-1:0] cnt, logic inc, logic dec);
        return cnt + CNT_W'(inc) - CNT_W'(dec);
    endfunction

    assign wr_acc    = bus.wr_en && !full_p0;
    assign count_nxt = cnt_step(count_p0, wr_acc, rd_acc);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // Stage p0: pointers, occupancy and flags, all registered from the next count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_p0  <= '0;
            full_p0   <= 1'b0;
            afull_p0  <= 1'b0;
            aempty_p0 <= 1'b1;
            ovf_p0    <= 1'b0;
            udf_p0    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (ram_pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count_p0  <= count_nxt;
            full_p0   <= (count_nxt == CNT_W'(DEPTH));
            afull_p0  <= (count_nxt >= CNT_W'(AFULL_TH));
            aempty_p0 <= (count_nxt <= CNT_W'(AEMPTY_TH));
            ovf_p0    <= bus.wr_en && full_p0;
            udf_p0    <= bus.rd_en && empty_p0;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    typedef enum logic {EMPTY_OUT, VALID_OUT} out_state_e;

    out_state_e       state_p0;
    logic [CNT_W-1:0] ram_cnt_p0;

    // The RAM feeds the output register whenever it is vacant or being popped,
    // so a pop with more data queued presents the next word without a bubble.
    assign rd_acc  = bus.rd_en && (state_p0 == VALID_OUT);
    assign ram_pop = (ram_cnt_p0 != '0) && ((state_p0 == EMPTY_OUT) || rd_acc);

    // Stage p0: output holding register and its two-state occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0   <= EMPTY_OUT;
            empty_p0   <= 1'b1;
            dout_p0    <= '0;
            ram_cnt_p0 <= '0;
        end else begin
            ram_cnt_p0 <= cnt_step(ram_cnt_p0, wr_acc, ram_pop);
            if (ram_pop) begin
                state_p0 <= VALID_OUT;
                empty_p0 <= 1'b0;
                dout_p0  <= mem[rd_ptr];
            end else if (rd_acc) begin
                state_p0 <= EMPTY_OUT;
                empty_p0 <= 1'b1;
            end
        end
    end
`else
    assign rd_acc  = bus.rd_en && !empty_p0;
    assign ram_pop = rd_acc;

    // Stage p0: registered read port, holds its word until the next accepted read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            empty_p0 <= 1'b1;
            dout_p0  <= '0;
        end else begin
            empty_p0 <= (count_nxt == '0);
            if (rd_acc) begin
                dout_p0 <= mem[rd_ptr];
            end
        end
    end
`endif

    assign bus.dout         = dout_p0;
    assign bus.full         = full_p0;
    assign bus.empty        = empty_p0;
    assign bus.almost_full  = afull_p0;
    assign bus.almost_empty = aempty_p0;
    assign bus.data_count   = count_p0;
    assign bus.overflow     = ovf_p0;
    assign bus.underflow    = udf_p0;
endmodule
